sdpfifo: RTL and testbench
==========================

SDPFIFO -- requirements
Module: sdpfifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 6, log2 of the entry count (2**DEPTH entries).
REQ-002 The block SHALL have parameter WIDTH, default 32, data word width in bits.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port srst_n, input, 1, reset: synchronous, active-low.
REQ-005 The block SHALL have port in_valid, input, 1, the writer presents a word.
REQ-006 The block SHALL have port in_ready, output, 1, the block accepts a word this cycle.
REQ-007 The block SHALL have port in_data, input, WIDTH, the write word.
REQ-008 The block SHALL have port out_valid, output, 1, out_data holds the oldest stored word.
REQ-009 The block SHALL have port out_ready, input, 1, the reader consumes the word this cycle.
REQ-010 The block SHALL have port out_data, output, WIDTH, the oldest stored word (show-ahead).
REQ-011 The block SHALL have port level, output, DEPTH+1, occupancy; present only under SDPFIFO_LEVEL_EN.

Function
REQ-012 Push SHALL occur on a rising edge where in_valid and in_ready are both 1; in_data is written at wr_ptr and wr_ptr increments.
REQ-013 Pop SHALL occur on a rising edge where out_valid and out_ready are both 1; rd_ptr increments.
REQ-014 wr_ptr and rd_ptr SHALL each be DEPTH+1 bits and wrap modulo 2**(DEPTH+1); the MSB is the lap bit and the low DEPTH bits address storage.
REQ-015 Empty SHALL be defined as wr_ptr == rd_ptr.
REQ-016 Full SHALL be defined as low DEPTH bits equal and MSBs differing.
REQ-017 in_ready SHALL equal (not full) AND srst_n, combinationally.
REQ-018 out_valid SHALL equal (not empty), as a function of registered state only.
REQ-019 out_data SHALL be the combinational read of storage at rd_ptr[DEPTH-1:0]; its value is don't-care when out_valid is 0.
REQ-020 Write-to-read latency SHALL be one cycle: a word pushed into an empty FIFO at edge N gives out_valid=1 and that word on out_data after edge N.
REQ-021 Simultaneous push and pop when neither full nor empty SHALL both take effect in the same cycle and leave occupancy unchanged.
REQ-022 When full, a push SHALL NOT be accepted even if a pop occurs in the same cycle; no pass-through.
REQ-023 When empty, a pop SHALL NOT be possible and in_data SHALL NOT bypass to out_data.
REQ-024 in_valid held while in_ready is 0 SHALL have no effect; in_data need not be stable.
REQ-025 Storage contents SHALL NOT be cleared by reset; only the pointers are.
REQ-026 Word order SHALL be strict FIFO, with no loss or duplication across pointer wrap-around.

Reset
REQ-027 On a rising edge with srst_n=0, wr_ptr and rd_ptr SHALL both be set to 0, giving out_valid=0 and level=0 after the edge.
REQ-028 Reset asserted mid-operation SHALL discard all stored words and block any push or pop on that edge.
REQ-029 in_ready SHALL be 0 while srst_n=0, and 1 in the first cycle after srst_n returns to 1.

Configuration
REQ-030 With the macro SDPFIFO_LEVEL_EN defined, port level SHALL exist and equal wr_ptr - rd_ptr modulo 2**(DEPTH+1), ranging 0..2**DEPTH, registered-state derived.
REQ-031 Without SDPFIFO_LEVEL_EN, port level and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-032 The storage SHALL be one instance of sub-module asdpmem: DEPTH and WIDTH passed through, clka=clk, ena=1, wea=push, addra=wr_ptr low bits, addrb=rd_ptr low bits.
REQ-033 A shared package sdpfifo_pkg SHALL hold the pointer-width constant rule (DEPTH+1) and the full/empty compare helpers; no other typedefs are required.

Verification
REQ-034 Reset, then idle: out_valid=0, in_ready=1, level=0.
REQ-035 DEPTH=2: push 0xA1..0xA4 back-to-back -> in_ready=0 after the 4th push, level=4; a 5th in_valid is ignored.
REQ-036 Pop four words -> out_data reads 0xA1, 0xA2, 0xA3, 0xA4 in order, then out_valid=0.
REQ-037 Push and pop together for 20 cycles at level=2 (DEPTH=2) -> level stays 2 and order is preserved across several pointer wraps.
REQ-038 At full with in_valid=out_ready=1 -> exactly one pop and no push; level goes 4 to 3.
REQ-039 srst_n=0 for one edge at level=3 -> next cycle out_valid=0 and level=0; a subsequent push of 0x5A is read back as 0x5A.

Source files
------------

// File: rtl/sdpfifo_pkg.sv
// Shared definitions for the sdpfifo block: pointer width rule and the
// full/empty compare helpers used on the read/write pointers.
package sdpfifo_pkg;

    // Widest pointer the helpers accept; callers zero-extend to this width.
    localparam int unsigned PTR_MAX = 32;

    // Pointers carry one extra lap bit above the storage address bits.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return depth + 32'd1;
    endfunction

    // Same lap and same address: nothing stored.
    function automatic logic ptr_empty(input logic [PTR_MAX-1:0] wr,
                                       input logic [PTR_MAX-1:0] rd);
        return (wr == rd);
    endfunction

    // Same address but opposite lap bit: writer is one full lap ahead.
    function automatic logic ptr_full(input logic [PTR_MAX-1:0] wr,
                                      input logic [PTR_MAX-1:0] rd,
                                      input int unsigned        depth);
        return ((wr ^ rd) == (32'd1 << depth));
    endfunction

endpackage

// File: rtl/sdpfifo_mem.sv
// asdpmem: simple dual-port storage, synchronous write on port A and
// combinational (asynchronous) read on port B. Contents are never reset.
module asdpmem #(
    parameter int unsigned DEPTH = 6,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clka,
    input  logic             ena,
    input  logic             wea,
    input  logic [DEPTH-1:0] addra,
    input  logic [WIDTH-1:0] dina,
    input  logic [DEPTH-1:0] addrb,
    output logic [WIDTH-1:0] doutb
);

    logic [WIDTH-1:0] mem_r [2**DEPTH];

    // Write port: store dina at addra when enabled and write-enabled.
    always_ff @(posedge clka) begin
        if (ena && wea) begin
            mem_r[addra] <= dina;
        end
    end

    assign doutb = mem_r[addrb];

endmodule

// File: rtl/sdpfifo.sv
// sdpfifo: show-ahead synchronous FIFO with valid/ready handshakes on both
// sides, built on one asdpmem instance. Optional occupancy port enabled by
// defining SDPFIFO_LEVEL_EN.
module sdpfifo
    import sdpfifo_pkg::*;
#(
    parameter int unsigned DEPTH = 6,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             srst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef SDPFIFO_LEVEL_EN
    ,
    output logic [DEPTH:0]   level
`endif
);

    localparam int unsigned   PW      = ptr_width(DEPTH);
    localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic          empty_s;
    logic          full_s;
    logic          push_s;
    logic          pop_s;

    // Status flags and handshakes; all derived from registered pointers,
    // except in_ready which is also gated by reset.
    always_comb begin
        empty_s   = ptr_empty({{(PTR_MAX-PW){1'b0}}, wr_ptr_r},
                              {{(PTR_MAX-PW){1'b0}}, rd_ptr_r});
        full_s    = ptr_full({{(PTR_MAX-PW){1'b0}}, wr_ptr_r},
                             {{(PTR_MAX-PW){1'b0}}, rd_ptr_r}, DEPTH);
        in_ready  = !full_s && srst_n;
        out_valid = !empty_s;
        push_s    = in_valid && in_ready;
        pop_s     = out_valid && out_ready;
    end

    // Pointer update: reset clears both; otherwise advance on push / pop.
    always_ff @(posedge clk) begin
        if (!srst_n) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    asdpmem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_mem (
        .clka  (clk),
        .ena   (1'b1),
        .wea   (push_s),
        .addra (wr_ptr_r[DEPTH-1:0]),
        .dina  (in_data),
        .addrb (rd_ptr_r[DEPTH-1:0]),
        .doutb (out_data)
    );

`ifdef SDPFIFO_LEVEL_EN
    // Occupancy: modular pointer difference, 0 .. 2**DEPTH.
    assign level = wr_ptr_r - rd_ptr_r;
`endif

endmodule

// File: tb/tb_sdpfifo.sv
// Self-checking bench for sdpfifo (DEPTH=2) against a queue-based model.
// Builds with or without SDPFIFO_LEVEL_EN.
module tb_sdpfifo;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned WIDTH = 32;
    localparam int          CAP   = 4;

    logic             clk = 1'b0;
    logic             srst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = 32'd0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
`ifdef SDPFIFO_LEVEL_EN
    logic [DEPTH:0]   level;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [WIDTH-1:0] model_q [$];

    sdpfifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .srst_n    (srst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef SDPFIFO_LEVEL_EN
        ,
        .level     (level)
`endif
    );

    always #5 clk = ~clk;

    // Single comparison point: counts and reports mismatches.
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs, check outputs against the model, then clock
    // the model with the same decision rules as the FIFO contract.
    task automatic step(input logic rst_n_i, input logic iv, input logic ordy,
                        input logic [WIDTH-1:0] d);
        bit do_push;
        bit do_pop;
        @(negedge clk);
        srst_n    = rst_n_i;
        in_valid  = iv;
        out_ready = ordy;
        in_data   = d;
        #1;
        check_eq("out_valid", {31'd0, out_valid}, {31'd0, model_q.size() != 0});
        check_eq("in_ready", {31'd0, in_ready},
                 {31'd0, (rst_n_i == 1'b1) && (model_q.size() != CAP)});
        if (model_q.size() != 0) begin
            check_eq("out_data", out_data, model_q[0]);
        end
`ifdef SDPFIFO_LEVEL_EN
        check_eq("level", {29'd0, level}, model_q.size());
`endif
        @(posedge clk);
        if (!rst_n_i) begin
            model_q.delete();
        end else begin
            do_pop  = (model_q.size() != 0) && ordy;
            do_push = (model_q.size() < CAP) && iv;
            if (do_pop) begin
                void'(model_q.pop_front());
            end
            if (do_push) begin
                model_q.push_back(d);
            end
        end
    endtask

    initial begin
        // Reset then idle.
        step(1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'd0);

        // Fill with A1..A4, then a 5th write attempt while full.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'hA1 + 32'(i));
        end
        step(1'b1, 1'b1, 1'b0, 32'hEE);
        step(1'b1, 1'b0, 1'b0, 32'd0);

        // Drain four words in order, then observe empty.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b1, 32'd0);
        end
        step(1'b1, 1'b1, 1'b1, 32'h77);   // pop on empty must not happen
        step(1'b1, 1'b0, 1'b1, 32'd0);    // remove the word pushed above

        // Bring level to 2 and stream push+pop for 20 cycles.
        step(1'b1, 1'b1, 1'b0, 32'h100);
        step(1'b1, 1'b1, 1'b0, 32'h101);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 1'b1, 32'h102 + 32'(i));
        end

        // Top up to full, then push+pop together at full.
        step(1'b1, 1'b1, 1'b0, 32'h200);
        step(1'b1, 1'b1, 1'b0, 32'h201);
        step(1'b1, 1'b1, 1'b1, 32'h202);
        step(1'b1, 1'b0, 1'b0, 32'd0);

        // Reset at level 3, then push 0x5A and read it back.
        step(1'b0, 1'b1, 1'b1, 32'h33);
        step(1'b1, 1'b1, 1'b0, 32'h5A);
        step(1'b1, 1'b0, 1'b1, 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'd0);

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(63) != 0) ? 1'b1 : 1'b0,
                 1'($urandom_range(1)), 1'($urandom_range(1)), $urandom);
        end
        step(1'b1, 1'b0, 1'b0, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
